// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus issue FSM that drives a combinational yAlu and returns its result on a valid/ready port.
// Optional result checker enabled by defining ALU_SELFCHECK_EN; default build ties chk_err low.
module alu_cmd_issuer #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_z,
    input  logic         alu_ex,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_z,
    output logic         res_zero,
    output logic [2:0]   res_op,
    output logic         busy,
    output logic         chk_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_RES
    } state_e;

    state_e        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty;
    logic          push, pop, capture, release_res;

    logic [W-1:0]  alu_a_q, alu_b_q;
    logic [2:0]    alu_op_q;
    logic          res_valid_q;
    logic [W-1:0]  res_z_q;
    logic          res_zero_q;
    logic [2:0]    res_op_q;

    // Full/empty come from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!empty) state_d = S_SETTLE;
            S_SETTLE:   state_d = S_WAIT_RES;
            S_WAIT_RES: if (res_ready) state_d = empty ? S_IDLE : S_SETTLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            S_IDLE:     pop = !empty;
            S_SETTLE:   capture = 1'b1;
            S_WAIT_RES: begin
                release_res = res_ready;
                pop         = res_ready && !empty;
            end
            default: ;
        endcase
    end

    // NOTE: the storage array has no reset; count_q gates every read, so stale contents are never issued.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_z_q     <= '0;
            res_zero_q  <= 1'b0;
            res_op_q    <= '0;
        end else begin
            if (pop) begin
                alu_a_q  <= mem_q[rd_ptr_q].a;
                alu_b_q  <= mem_q[rd_ptr_q].b;
                alu_op_q <= mem_q[rd_ptr_q].op;
            end
            if (capture) begin
                res_valid_q <= 1'b1;
                res_z_q     <= alu_z;
                res_zero_q  <= alu_ex;
                res_op_q    <= alu_op_q;
            end else if (release_res) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_z     = res_z_q;
    assign res_zero  = res_zero_q;
    assign res_op    = res_op_q;
    assign busy      = !empty || (state_q != S_IDLE);

`ifdef ALU_SELFCHECK_EN
    logic [W-1:0] exp_z;
    logic         mismatch;
    logic         chk_err_q;

    // Reference result; SLT compares unsigned, undefined opcodes are expected to return zero.
    always_comb begin
        exp_z = '0;
        case (alu_op_q)
            3'b000:  exp_z = alu_a_q & alu_b_q;
            3'b001:  exp_z = alu_a_q | alu_b_q;
            3'b010:  exp_z = alu_a_q + alu_b_q;
            3'b110:  exp_z = alu_a_q - alu_b_q;
            3'b111:  exp_z[0] = (alu_a_q < alu_b_q);
            default: exp_z = '0;
        endcase
        mismatch = (alu_z != exp_z) || (alu_ex != (exp_z == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if (capture && mismatch) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural yAlu on the alu_* port and optional result corruption.
module tb_alu_cmd_issuer;

    localparam int W = 32;

`ifdef ALU_SELFCHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a, cmd_b;
    logic [2:0]   cmd_op;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_z;
    logic         alu_ex;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_z;
    logic         res_zero;
    logic [2:0]   res_op;
    logic         busy;
    logic         chk_err;

    logic         corrupt;
    logic [W-1:0] alu_model;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_z4  [5];
    logic [2:0]   exp_op4 [5];

    alu_cmd_issuer #(.W(W), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .alu_ex    (alu_ex),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_zero  (res_zero),
        .res_op    (res_op),
        .busy      (busy),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    // Behavioural yAlu; corrupt flips bit 0 of the result to emulate a faulty datapath.
    always_comb begin
        case (alu_op)
            3'b000:  alu_model = alu_a & alu_b;
            3'b001:  alu_model = alu_a | alu_b;
            3'b010:  alu_model = alu_a + alu_b;
            3'b110:  alu_model = alu_a - alu_b;
            3'b111:  alu_model = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_model = '0;
        endcase
    end
    assign alu_z  = alu_model ^ W'(corrupt);
    assign alu_ex = (alu_z == '0);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string tag, output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_res_valid"}, W'(res_valid), 32'd1);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int n;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("push_ready", W'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        res_ready = 1'b0;
        corrupt   = 1'b0;

        exp_z4  = '{32'h0000_00F0, 32'h0000_F00F, 32'd123, 32'd7, 32'd0};
        exp_op4 = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

        // Reset held 3 cycles, then release.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_res_valid", W'(res_valid), 32'd0);
        check("rst_res_z",     res_z,         32'd0);
        check("rst_alu_a",     alu_a,         32'd0);
        check("rst_alu_op",    W'(alu_op),    32'd0);
        check("rst_cmd_ready", W'(cmd_ready), 32'd1);
        check("rst_busy",      W'(busy),      32'd0);
        check("rst_chk_err",   W'(chk_err),   32'd0);

        // 5 + 3 with exact latency: accept at edge k, pop at k+1, result after k+2.
        res_ready = 1'b1;
        cmd_a = 32'd5; cmd_b = 32'd3; cmd_op = 3'b010; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_k_busy",      W'(busy),      32'd1);
        check("lat_k_res_valid", W'(res_valid), 32'd0);
        tick();
        check("lat_k1_alu_a",     alu_a,         32'd5);
        check("lat_k1_alu_b",     alu_b,         32'd3);
        check("lat_k1_alu_op",    W'(alu_op),    32'd2);
        check("lat_k1_res_valid", W'(res_valid), 32'd0);
        tick();
        check("lat_k2_res_valid", W'(res_valid), 32'd1);
        check("add_res_z",        res_z,         32'd8);
        check("add_res_zero",     W'(res_zero),  32'd0);
        check("add_res_op",       W'(res_op),    32'd2);
        tick();
        check("add_done_valid",   W'(res_valid), 32'd0);
        check("add_done_busy",    W'(busy),      32'd0);

        // SUB to zero.
        push(32'h0000_00FF, 32'h0000_00FF, 3'b110);
        wait_res("sub", n);
        check("sub_res_z",    res_z,        32'd0);
        check("sub_res_zero", W'(res_zero), 32'd1);
        check("sub_res_op",   W'(res_op),   32'd6);
        tick();

        // Back-pressure: 1 in flight + 4 queued fills the FIFO.
        res_ready = 1'b0;
        push(32'h0000_F0F0, 32'h0000_0FF0, 3'b000);
        push(32'h0000_F000, 32'h0000_000F, 3'b001);
        push(32'd100,       32'd23,        3'b010);
        push(32'd10,        32'd3,         3'b110);
        push(32'd2,         32'd1,         3'b111);
        check("full_cmd_ready", W'(cmd_ready), 32'd0);
        check("full_busy",      W'(busy),      32'd1);
        tick();
        tick();
        check("hold_res_valid", W'(res_valid), 32'd1);
        check("hold_res_z",     res_z,         32'h0000_00F0);
        check("hold_cmd_ready", W'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        #1;
        check("no_passthru_cmd_ready", W'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_res("drain", n);
            if (i > 0) check("drain_gap", n, 32'd1);
            check("drain_res_z",  res_z,      exp_z4[i]);
            check("drain_res_op", W'(res_op), W'(exp_op4[i]));
            tick();
        end
        check("drain_busy", W'(busy), 32'd0);

        // Wrap-around ADD, unsigned SLT, undefined opcode.
        push(32'hFFFF_FFFF, 32'd1, 3'b010);
        wait_res("wrap", n);
        check("wrap_res_z",    res_z,        32'd0);
        check("wrap_res_zero", W'(res_zero), 32'd1);
        tick();
        push(32'd1, 32'd2, 3'b111);
        wait_res("slt", n);
        check("slt_res_z",    res_z,        32'd1);
        check("slt_res_zero", W'(res_zero), 32'd0);
        tick();
        push(32'h12, 32'h34, 3'b011);
        wait_res("undef", n);
        check("undef_res_z",  res_z,      32'd0);
        check("undef_res_op", W'(res_op), 32'd3);
        tick();

        // Reset in WAIT_RES with commands queued discards everything.
        res_ready = 1'b0;
        push(32'd1, 32'd1, 3'b010);
        push(32'd2, 32'd2, 3'b010);
        push(32'd3, 32'd3, 3'b010);
        wait_res("pre_rst", n);
        check("pre_rst_busy", W'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_res_valid", W'(res_valid), 32'd0);
        check("mid_rst_busy",      W'(busy),      32'd0);
        check("mid_rst_cmd_ready", W'(cmd_ready), 32'd1);
        check("mid_rst_alu_a",     alu_a,         32'd0);
        check("mid_rst_res_z",     res_z,         32'd0);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_res_valid", W'(res_valid), 32'd0);
        end
        check("post_rst_busy", W'(busy), 32'd0);

        // Injected bad result: checker fires with res_valid and stays set.
        corrupt = 1'b1;
        push(32'd1, 32'd1, 3'b000);
        wait_res("bad", n);
        check("bad_res_z",   res_z,        32'd0);
        check("bad_chk_err", W'(chk_err),  W'(EXP_CHK));
        tick();
        corrupt = 1'b0;
        push(32'd3, 32'd5, 3'b001);
        wait_res("good", n);
        check("good_res_z",     res_z,       32'd7);
        check("sticky_chk_err", W'(chk_err), W'(EXP_CHK));
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_clears_chk_err", W'(chk_err), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
